// File: rtl/soc_gpio_pkg.sv
// soc_gpio_pkg: shared constants for the GPIO bank.
// Holds the register word addresses and the edge-capture polarity encodings
// used by soc_gpio_bank and soc_gpio_sync.
package soc_gpio_pkg;

    // Register map (word addresses on the Avalon-MM slave port)
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    // Edge-capture polarity selections for the EDGE_TYPE parameter
    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // A bus write happens only when the slave is selected and the
    // active-low strobe is asserted.
    function automatic logic isWrite(input logic chipSel, input logic writeN);
        return chipSel & ~writeN;
    endfunction

endpackage : soc_gpio_pkg

// File: rtl/soc_gpio_sync.sv
// soc_gpio_sync: input synchronizer and edge detector for the GPIO bank.
// Two flops (s1, s2) bring the asynchronous pins into the clk domain; s2 is
// the synchronized value. When SOC_GPIO_IRQ_EN is defined a third flop (s3)
// holds the previous synchronized value and edge_o flags the EDGE_TYPE
// transitions between s3 and s2. Without the macro there is no s3 stage and
// no edge output.
module soc_gpio_sync
    import soc_gpio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] sync_o
`ifdef SOC_GPIO_IRQ_EN
    ,
    output logic [WIDTH-1:0] edge_o
`endif
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Two-stage metastability synchronizer; cleared immediately by reset so
    // that pins held high through reset release look like a fresh rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pins_i;
            s2_q <= s1_q;
        end
    end

    assign sync_o = s2_q;

`ifdef SOC_GPIO_IRQ_EN
    logic [WIDTH-1:0] s3_q;

    // Delayed copy of the synchronized value, the reference for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_q <= '0;
        end else begin
            s3_q <= s2_q;
        end
    end

    // Select which transitions of the synchronized input count as an edge.
    always_comb begin
        edge_o = '0;
        case (EDGE_TYPE)
            EDGE_FALLING: edge_o = ~s2_q & s3_q;
            EDGE_ANY:     edge_o = s2_q ^ s3_q;
            default:      edge_o = s2_q & ~s3_q;
        endcase
    end
`endif

endmodule : soc_gpio_sync

// File: rtl/soc_gpio_bank.sv
// soc_gpio_bank: Avalon-MM GPIO bank with per-bit direction, atomic output
// set/clear, synchronized inputs and optional edge capture with a maskable
// level interrupt.
// Build option: define SOC_GPIO_IRQ_EN to include the EDGECAP and IRQMASK
// registers and the irq output. Without it addresses 2 and 3 read 0, ignore
// writes, and irq is tied low.
module soc_gpio_bank
    import soc_gpio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic             writeEn;
    logic [WIDTH-1:0] writeBits;
    logic             unusedWriteData;

    logic [WIDTH-1:0] dataOut_q;
    logic [WIDTH-1:0] dataOut_d;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] dir_d;
    logic [WIDTH-1:0] syncIn;
    logic [WIDTH-1:0] readBits;

    assign writeEn         = isWrite(chipselect, write_n);
    assign writeBits       = writedata[WIDTH-1:0];
    assign unusedWriteData = ^writedata;

`ifdef SOC_GPIO_IRQ_EN
    logic [WIDTH-1:0] edgeHit;
    logic [WIDTH-1:0] irqMask_q;
    logic [WIDTH-1:0] irqMask_d;
    logic [WIDTH-1:0] edgeCap_q;
    logic [WIDTH-1:0] edgeCap_d;
`endif

    soc_gpio_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pins_i  (gpio_in),
        .sync_o  (syncIn)
`ifdef SOC_GPIO_IRQ_EN
        ,
        .edge_o  (edgeHit)
`endif
    );

    // Next value of the output data and direction registers from bus writes;
    // OUTSET/OUTCLR modify only the bits written as 1.
    always_comb begin
        dataOut_d = dataOut_q;
        dir_d     = dir_q;
        if (writeEn) begin
            case (address)
                ADDR_DATA:   dataOut_d = writeBits;
                ADDR_DIR:    dir_d     = writeBits;
                ADDR_OUTSET: dataOut_d = dataOut_q | writeBits;
                ADDR_OUTCLR: dataOut_d = dataOut_q & ~writeBits;
                default:     dataOut_d = dataOut_q;
            endcase
        end
    end

    // Output data and direction state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataOut_q <= RESET_VALUE;
            dir_q     <= DIR_RESET;
        end else begin
            dataOut_q <= dataOut_d;
            dir_q     <= dir_d;
        end
    end

    assign gpio_out = dataOut_q;
    assign gpio_oe  = dir_q;

`ifdef SOC_GPIO_IRQ_EN
    // Mask register write and edge capture; a fresh edge is OR-ed in after
    // the write-1-to-clear so capture wins when both hit the same bit.
    always_comb begin
        irqMask_d = irqMask_q;
        edgeCap_d = edgeCap_q;
        if (writeEn && (address == ADDR_IRQMASK)) begin
            irqMask_d = writeBits;
        end
        if (writeEn && (address == ADDR_EDGECAP)) begin
            edgeCap_d = edgeCap_q & ~writeBits;
        end
        edgeCap_d = edgeCap_d | edgeHit;
    end

    // Interrupt mask and captured-edge state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqMask_q <= '0;
            edgeCap_q <= '0;
        end else begin
            irqMask_q <= irqMask_d;
            edgeCap_q <= edgeCap_d;
        end
    end

    assign irq = |(edgeCap_q & irqMask_q);
`else
    assign irq = 1'b0;
`endif

    // Zero-wait-state read mux; output bits read the driven value, input
    // bits read the synchronized pin. Unused upper bits read 0.
    always_comb begin
        readBits = '0;
        case (address)
            ADDR_DATA:    readBits = (dataOut_q & dir_q) | (syncIn & ~dir_q);
            ADDR_DIR:     readBits = dir_q;
`ifdef SOC_GPIO_IRQ_EN
            ADDR_IRQMASK: readBits = irqMask_q;
            ADDR_EDGECAP: readBits = edgeCap_q;
`endif
            default:      readBits = '0;
        endcase
        readdata                = '0;
        readdata[WIDTH-1:0]     = readBits;
    end

endmodule : soc_gpio_bank
